// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-entry synchronous byte FIFO and serializes each
// byte on a UART line as 8N1 (start bit, 8 data bits LSB first, stop bit).
// The FIFO is popped with a one-cycle rd pulse; its registered data_out is
// captured one cycle later. All outputs come straight from flops, so the
// serial pin and handshake strobes cannot glitch.

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic [7:0] fifo_data,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    // Baud counter spans 0..CLKS_PER_BIT-1; keep at least one bit wide.
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [2:0]        BIT_LAST  = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [BAUD_W-1:0] baud_r;
    logic [BAUD_W-1:0] baud_s;
    logic [2:0]        bit_cnt_r;
    logic [2:0]        bit_cnt_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_s;
    logic              baud_wrap_s;

    logic              tx_s;
    logic              fifo_rd_s;
    logic              busy_s;
    logic              tx_done_s;

    // Line level driven while in a given state; data bits come from the
    // low end of the shift register.
    function automatic logic tx_level(input state_t st, input logic lsb);
        logic level;
        case (st)
            START:   level = 1'b0;
            DATA:    level = lsb;
            default: level = 1'b1;
        endcase
        return level;
    endfunction

    // Last clock of the current bit period.
    always_comb begin
        baud_wrap_s = (baud_r == BAUD_LAST);
    end

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        case (state_r)
            IDLE: begin
                // en and fifo_empty are only looked at here, so a frame in
                // flight always completes and the FIFO is never over-read.
                if (en && !fifo_empty) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                state_s = LOAD;
            end
            LOAD: begin
                // FIFO data_out is valid now, one cycle after the rd pulse.
                shift_s   = fifo_data;
                baud_s    = BAUD_ZERO;
                bit_cnt_s = 3'd0;
                state_s   = START;
            end
            START: begin
                if (baud_wrap_s) begin
                    baud_s  = BAUD_ZERO;
                    state_s = DATA;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_wrap_s) begin
                    baud_s  = BAUD_ZERO;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_s = 3'd0;
                        state_s   = STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_wrap_s) begin
                    baud_s  = BAUD_ZERO;
                    state_s = IDLE;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s   = IDLE;
                baud_s    = BAUD_ZERO;
                bit_cnt_s = 3'd0;
                shift_s   = 8'h00;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up exactly with the state they describe.
    always_comb begin
        tx_s      = tx_level(state_s, shift_s[0]);
        fifo_rd_s = (state_s == FETCH);
        busy_s    = (state_s != IDLE);
        tx_done_s = (state_s == STOP) && (baud_s == BAUD_LAST);
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            baud_r    <= BAUD_ZERO;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            tx        <= 1'b1;
            fifo_rd   <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            tx        <= tx_s;
            fifo_rd   <= fifo_rd_s;
            busy      <= busy_s;
            tx_done   <= tx_done_s;
        end
    end

endmodule
